// File: rtl/act_sigmoid_bwd.sv
// Sigmoid backward step: delta = g * y * (1 - y) in signed fixed point,
// computed by two sequential shift-add multiplies behind valid/ready handshakes.
module act_sigmoid_bwd #(
  parameter int unsigned PREC = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PREC-1:0] in_y,
  input  logic [PREC-1:0] in_g,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PREC-1:0] out_delta,
  output logic            busy
);

  localparam int unsigned AW = 2 * PREC;
  localparam int unsigned CW = $clog2(PREC + 1);
  localparam logic [PREC-1:0] ONE = PREC'(1) << FRAC;
  localparam logic [CW-1:0] LAST = CW'(PREC - 1);
  localparam logic [CW-1:0] FIN  = CW'(PREC);

  typedef enum logic [1:0] {IDLE, MUL_P, MUL_G, DONE} state_t;

  state_t          r_state, w_state_next;
  logic [AW-1:0]   r_acc, r_mcand;
  logic [PREC-1:0] r_mplier, r_gmag, r_delta;
  logic [CW-1:0]   r_cnt;
  logic            r_neg, r_out_valid;

  logic            w_accept, w_step, w_p_done, w_g_done, w_release;
  logic [PREC-1:0] w_y_clamp, w_g_mag, w_m;
  logic [AW-1:0]   w_acc_add;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_delta = r_delta;

  // Operand conditioning: saturate y into [0, ONE], take |g|
  always_comb begin
    w_y_clamp = in_y;
    if (in_y[PREC-1])   w_y_clamp = '0;
    else if (in_y > ONE) w_y_clamp = ONE;
    w_g_mag = in_g[PREC-1] ? (~in_g + PREC'(1)) : in_g;
  end

  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_m       = r_acc[FRAC +: PREC];

  // Next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_p_done     = 1'b0;
    w_g_done     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = MUL_P;
        end
      end
      MUL_P: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_p_done     = 1'b1;
          w_state_next = MUL_G;
        end
      end
      MUL_G: begin
        // Cycle after the last partial product applies scaling and sign
        if (r_cnt == FIN) begin
          w_g_done     = 1'b1;
          w_state_next = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Datapath: multiplicand shifts left, multiplier shifts right each step
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_gmag      <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_delta     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mcand  <= AW'(w_y_clamp);
        r_mplier <= ONE - w_y_clamp;
        r_gmag   <= w_g_mag;
        r_neg    <= in_g[PREC-1];
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_step) begin
        if (w_p_done) begin
          r_acc    <= '0;
          r_mcand  <= AW'(r_gmag);
          r_mplier <= w_acc_add[FRAC +: PREC];
          r_cnt    <= '0;
        end else begin
          r_acc    <= w_acc_add;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
      end
      if (w_g_done) begin
        r_delta     <= r_neg ? (~w_m + PREC'(1)) : w_m;
        r_out_valid <= 1'b1;
      end
      if (w_release) r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_act_sigmoid_bwd.sv
// Bench for act_sigmoid_bwd: vector table through a scoreboard queue plus
// latency, backpressure and mid-operation reset sequences.
module tb_act_sigmoid_bwd;

  localparam int unsigned PREC = 16;
  localparam int unsigned FRAC = 8;
  localparam int NV = 13;

  logic            clk = 1'b0;
  logic            reset_;
  logic            in_valid, in_ready, out_valid, out_ready, busy;
  logic [PREC-1:0] in_y, in_g, out_delta;

  always #5 clk = ~clk;

  act_sigmoid_bwd #(.PREC(PREC), .FRAC(FRAC)) dut (
    .clk(clk), .reset_(reset_),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_g(in_g),
    .out_valid(out_valid), .out_ready(out_ready), .out_delta(out_delta),
    .busy(busy)
  );

  typedef struct {
    logic [15:0] y;
    logic [15:0] g;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[NV];
  logic [15:0] q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Present an operand pair and hold it until the DUT accepts it
  task automatic send(input logic [15:0] y, input logic [15:0] g,
                      input logic [15:0] exp, input bit track);
    int n = 0;
    @(negedge clk);
    in_y = y; in_g = g; in_valid = 1'b1;
    if (track) q.push_back(exp);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a result is compared on the half-cycle before its handshake edge
  always @(negedge clk) begin
    if (reset_ && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_delta);
      end else begin
        chk("delta", 32'(out_delta), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    int  lat;
    bit  busy_ok;
    logic [15:0] held;

    vecs[0]  = '{16'h0080, 16'hFF00, 16'hFFC0};
    vecs[1]  = '{16'h0040, 16'h0200, 16'h0060};
    vecs[2]  = '{16'h0000, 16'h0100, 16'h0000};
    vecs[3]  = '{16'h0100, 16'h0100, 16'h0000};
    vecs[4]  = '{16'h0200, 16'h0100, 16'h0000};
    vecs[5]  = '{16'hFF80, 16'h0100, 16'h0000};
    vecs[6]  = '{16'h0080, 16'hFFFF, 16'h0000};
    vecs[7]  = '{16'h0080, 16'h0003, 16'h0000};
    vecs[8]  = '{16'h0080, 16'h8000, 16'hE000};
    vecs[9]  = '{16'h00C0, 16'h0400, 16'h00C0};
    vecs[10] = '{16'h0080, 16'h0000, 16'h0000};
    vecs[11] = '{16'h0010, 16'h7FFF, 16'h077F};
    vecs[12] = '{16'h0060, 16'hFD00, 16'hFF4C};

    reset_ = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_y = '0; in_g = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_delta", 32'(out_delta), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_ = 1'b1;

    // Latency and busy across the whole operation
    send(16'h0080, 16'h0100, 16'h0040, 1'b1);
    lat = 0; busy_ok = 1'b1;
    while (!out_valid && lat < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 32'(lat), 33);
    chk("busy_throughout", 32'(busy_ok), 1);
    drain();

    for (int i = 0; i < NV; i++) send(vecs[i].y, vecs[i].g, vecs[i].exp, 1'b1);
    drain();

    // Backpressure: result held in DONE while a new operand waits
    out_ready = 1'b0;
    send(16'h0040, 16'h0200, 16'h0060, 1'b1);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) timeout("bp_valid");
    held = out_delta;
    chk("bp_first", 32'(held), 32'h0060);
    in_y = 16'h0080; in_g = 16'h0100; in_valid = 1'b1;
    q.push_back(16'h0040);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_hold", 32'(out_valid), 1);
      chk("bp_delta_hold", 32'(out_delta), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("bp_pending_accepted", 32'(busy), 1);
    in_valid = 1'b0;
    drain();

    // Reset while in the second multiply discards the operation
    send(16'h0080, 16'h0100, 16'h0040, 1'b0);
    repeat (20) @(posedge clk);
    #1 reset_ = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_delta", 32'(out_delta), 0);
    chk("midrst_busy", 32'(busy), 0);
    reset_ = 1'b1;
    repeat (40) @(posedge clk);
    send(16'h0080, 16'h0100, 16'h0040, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
